// File: rtl/sap_pkg.sv
// Shared opcodes, state encoding and control-word layout
// for the SAP instruction controller.
package sap_pkg;

    localparam int OPW = 4;

    localparam logic [OPW-1:0] OP_NOP = 4'b0000;
    localparam logic [OPW-1:0] OP_LDA = 4'b0001;
    localparam logic [OPW-1:0] OP_ADD = 4'b0010;
    localparam logic [OPW-1:0] OP_SUB = 4'b0011;
    localparam logic [OPW-1:0] OP_LDB = 4'b0100;
    localparam logic [OPW-1:0] OP_OUT = 4'b1110;
    localparam logic [OPW-1:0] OP_HLT = 4'b1111;

    typedef enum logic [3:0] {
        S_BOOT,
        S_WAIT,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_t;

    typedef struct packed {
        logic cp;
        logic ep;
        logic lm;
        logic ce;
        logic li;
        logic ei;
        logic la;
        logic ea;
        logic su;
        logic eu;
        logic lb;
        logic lo;
    } ctrl_t;

    localparam ctrl_t CW_NONE = '0;
    localparam ctrl_t CW_T1 = '{ep: 1'b1, lm: 1'b1, default: 1'b0};
    localparam ctrl_t CW_T2 = '{cp: 1'b1, default: 1'b0};
    localparam ctrl_t CW_T3 = '{ce: 1'b1, li: 1'b1, default: 1'b0};

    localparam ctrl_t CW_ADDR = '{ei: 1'b1, lm: 1'b1, default: 1'b0};
    localparam ctrl_t CW_LD_A = '{ce: 1'b1, la: 1'b1, default: 1'b0};
    localparam ctrl_t CW_LD_B = '{ce: 1'b1, lb: 1'b1, default: 1'b0};
    localparam ctrl_t CW_ADD6 = '{la: 1'b1, eu: 1'b1, default: 1'b0};
    localparam ctrl_t CW_SUB6 = '{la: 1'b1, su: 1'b1, eu: 1'b1,
                                  default: 1'b0};
    localparam ctrl_t CW_OUT4 = '{ea: 1'b1, lo: 1'b1, default: 1'b0};

    function automatic logic [5:0] t_onehot(state_t s);
        case (s)
            S_T1:    return 6'b000001;
            S_T2:    return 6'b000010;
            S_T3:    return 6'b000100;
            S_T4:    return 6'b001000;
            S_T5:    return 6'b010000;
            S_T6:    return 6'b100000;
            default: return 6'b000000;
        endcase
    endfunction

endpackage

// File: rtl/sap_step_sync.sv
// Samples step_go on the falling edge and flags the
// edge where it is first seen high.
module sap_step_sync (
    input  logic clk,
    input  logic reset,
    input  logic step_go,
    output logic step_rise
);

    logic prev_q;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= step_go;
        end
    end

    assign step_rise = step_go & ~prev_q;

endmodule

// File: rtl/sap_control_unit.sv
// SAP instruction controller: six-phase ring sequencer,
// opcode decode, halt and single-step handshake.
module sap_control_unit
    import sap_pkg::*;
#(
    parameter int EARLY_END = 1,
    parameter int OPW       = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic           step_en,
    input  logic           step_go,
    output logic           Cp,
    output logic           Ep,
    output logic           Lm,
    output logic           Ce,
    output logic           Li,
    output logic           Ei,
    output logic           La,
    output logic           Ea,
    output logic           Su,
    output logic           Eu,
    output logic           Lb,
    output logic           Lo,
    output logic [5:0]     t_state,
    output logic           instr_done,
    output logic           halted
);

    state_t         state;
    state_t         state_n;
    logic [OPW-1:0] op_q;
    logic           step_rise;
    logic           last;
    state_t         boundary;
    ctrl_t          cw;

    sap_step_sync u_step (
        .clk       (clk),
        .reset     (reset),
        .step_go   (step_go),
        .step_rise (step_rise)
    );

    function automatic logic is_last(state_t s, logic [OPW-1:0] op);
        if (op == OP_HLT) begin
            return 1'b0;
        end
        if (EARLY_END == 0) begin
            return s == S_T6;
        end
        case (op)
            OP_LDA, OP_LDB: return s == S_T5;
            OP_ADD, OP_SUB: return s == S_T6;
            default:        return s == S_T4;
        endcase
    endfunction

    function automatic ctrl_t decode(state_t s, logic [OPW-1:0] op);
        ctrl_t w;
        w = CW_NONE;
        case (s)
            S_T1: w = CW_T1;
            S_T2: w = CW_T2;
            S_T3: w = CW_T3;
            S_T4: begin
                case (op)
                    OP_LDA, OP_LDB,
                    OP_ADD, OP_SUB: w = CW_ADDR;
                    OP_OUT:         w = CW_OUT4;
                    default:        w = CW_NONE;
                endcase
            end
            S_T5: begin
                case (op)
                    OP_LDA:         w = CW_LD_A;
                    OP_LDB, OP_ADD,
                    OP_SUB:         w = CW_LD_B;
                    default:        w = CW_NONE;
                endcase
            end
            S_T6: begin
                case (op)
                    OP_ADD:  w = CW_ADD6;
                    OP_SUB:  w = CW_SUB6;
                    default: w = CW_NONE;
                endcase
            end
            default: w = CW_NONE;
        endcase
        return w;
    endfunction

    // op_q latches on the edge entering T4; later opcode
    // changes cannot disturb the running instruction
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_BOOT;
            op_q  <= '0;
        end else begin
            state <= state_n;
            if (state == S_T3) begin
                op_q <= opcode;
            end
        end
    end

    always_comb begin
        last     = is_last(state, op_q);
        boundary = step_en ? S_WAIT : S_T1;
        state_n  = state;
        case (state)
            S_BOOT: state_n = boundary;
            S_WAIT: begin
                if (!step_en || step_rise) begin
                    state_n = S_T1;
                end
            end
            S_T1: state_n = S_T2;
            S_T2: state_n = S_T3;
            S_T3: state_n = S_T4;
            S_T4: begin
                if (op_q == OP_HLT) begin
                    state_n = S_HALT;
                end else if (last) begin
                    state_n = boundary;
                end else begin
                    state_n = S_T5;
                end
            end
            S_T5: state_n = last ? boundary : S_T6;
            S_T6: state_n = boundary;
            S_HALT: state_n = S_HALT;
            default: state_n = S_BOOT;
        endcase
    end

    assign cw = decode(state, op_q);

    assign Cp = cw.cp;
    assign Ep = cw.ep;
    assign Lm = cw.lm;
    assign Ce = cw.ce;
    assign Li = cw.li;
    assign Ei = cw.ei;
    assign La = cw.la;
    assign Ea = cw.ea;
    assign Su = cw.su;
    assign Eu = cw.eu;
    assign Lb = cw.lb;
    assign Lo = cw.lo;

    assign t_state    = t_onehot(state);
    assign instr_done = last;
    assign halted     = (state == S_HALT);

endmodule

// File: tb/tb_sap_control_unit.sv
// Bench for sap_control_unit: vector table, directed corner
// sequences and random traffic against a reference model.
module tb_sap_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic       step_en = 1'b0;
    logic       step_go = 1'b0;

    logic [11:0] c1, c0;
    logic [5:0]  t1s, t0s;
    logic        d1, d0, h1, h0;

    localparam logic [11:0] CP = 12'h800, EP = 12'h400, LM = 12'h200;
    localparam logic [11:0] CE = 12'h100, LI = 12'h080, EI = 12'h040;
    localparam logic [11:0] LA = 12'h020, EA = 12'h010, SU = 12'h008;
    localparam logic [11:0] EU = 12'h004, LB = 12'h002, LO = 12'h001;

    localparam int M_BOOT = 0, M_WAIT = 1, M_RUN = 2, M_HALT = 3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sap_control_unit #(.EARLY_END(1), .OPW(4)) u_ee1 (
        .clk(clk), .reset(reset), .opcode(opcode),
        .step_en(step_en), .step_go(step_go),
        .Cp(c1[11]), .Ep(c1[10]), .Lm(c1[9]), .Ce(c1[8]),
        .Li(c1[7]), .Ei(c1[6]), .La(c1[5]), .Ea(c1[4]),
        .Su(c1[3]), .Eu(c1[2]), .Lb(c1[1]), .Lo(c1[0]),
        .t_state(t1s), .instr_done(d1), .halted(h1)
    );

    sap_control_unit #(.EARLY_END(0), .OPW(4)) u_ee0 (
        .clk(clk), .reset(reset), .opcode(opcode),
        .step_en(step_en), .step_go(step_go),
        .Cp(c0[11]), .Ep(c0[10]), .Lm(c0[9]), .Ce(c0[8]),
        .Li(c0[7]), .Ei(c0[6]), .La(c0[5]), .Ea(c0[4]),
        .Su(c0[3]), .Eu(c0[2]), .Lb(c0[1]), .Lo(c0[0]),
        .t_state(t0s), .instr_done(d0), .halted(h0)
    );

    // ---------------- reference model ----------------
    int         m_mode[2] = '{M_BOOT, M_BOOT};
    int         m_t[2]    = '{1, 1};
    logic [3:0] m_op[2]   = '{4'h0, 4'h0};
    logic       m_prev    = 1'b0;

    function automatic int ilen(logic [3:0] op, int ee);
        if (ee == 0) return 6;
        case (op)
            4'h1, 4'h4: return 5;
            4'h2, 4'h3: return 6;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [11:0] ectrl(int mode, int t, logic [3:0] op);
        if (mode != M_RUN) return 12'h000;
        case (t)
            1: return EP | LM;
            2: return CP;
            3: return CE | LI;
            4: begin
                if (op >= 4'h1 && op <= 4'h4) return EI | LM;
                if (op == 4'hE) return EA | LO;
                return 12'h000;
            end
            5: begin
                if (op == 4'h1) return CE | LA;
                if (op >= 4'h2 && op <= 4'h4) return CE | LB;
                return 12'h000;
            end
            6: begin
                if (op == 4'h2) return LA | EU;
                if (op == 4'h3) return LA | SU | EU;
                return 12'h000;
            end
            default: return 12'h000;
        endcase
    endfunction

    function automatic logic [19:0] eout(int v);
        logic [5:0] t;
        logic       d;
        t = 6'b0;
        d = 1'b0;
        if (m_mode[v] == M_RUN) begin
            t = 6'b1 << (m_t[v] - 1);
            d = (m_op[v] != 4'hF) && (m_t[v] == ilen(m_op[v], v));
        end
        return {ectrl(m_mode[v], m_t[v], m_op[v]), t, d,
                m_mode[v] == M_HALT};
    endfunction

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < 2; v++) begin
                m_mode[v] <= M_BOOT;
                m_t[v]    <= 1;
                m_op[v]   <= 4'h0;
            end
            m_prev <= 1'b0;
        end else begin
            m_prev <= step_go;
            for (int v = 0; v < 2; v++) begin
                case (m_mode[v])
                    M_BOOT: begin
                        m_mode[v] <= step_en ? M_WAIT : M_RUN;
                        m_t[v]    <= 1;
                    end
                    M_WAIT: begin
                        if (!step_en || (step_go && !m_prev)) begin
                            m_mode[v] <= M_RUN;
                            m_t[v]    <= 1;
                        end
                    end
                    M_RUN: begin
                        if (m_t[v] == 3) m_op[v] <= opcode;
                        if (m_t[v] == 4 && m_op[v] == 4'hF) begin
                            m_mode[v] <= M_HALT;
                        end else if (m_t[v] == ilen(m_op[v], v)) begin
                            m_mode[v] <= step_en ? M_WAIT : M_RUN;
                            m_t[v]    <= 1;
                        end else begin
                            m_t[v] <= m_t[v] + 1;
                        end
                    end
                    default: m_mode[v] <= M_HALT;
                endcase
            end
        end
    end

    // at most one bus driver, in either variant
    always @(posedge clk) begin
        if (reset) begin
            assert ($countones({c1[10], c1[8], c1[6], c1[4], c1[2]}) <= 1)
            else $error("FAIL bus_drivers_ee1: %b", c1);
            assert ($countones({c0[10], c0[8], c0[6], c0[4], c0[2]}) <= 1)
            else $error("FAIL bus_drivers_ee0: %b", c0);
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [19:0] act,
                       input logic [19:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] op,
                        input logic en, input logic go);
        @(posedge clk);
        #1;
        reset   = r;
        opcode  = op;
        step_en = en;
        step_go = go;
        #1;
        chk("model_ee1", {c1, t1s, d1, h1}, eout(1));
        chk("model_ee0", {c0, t0s, d0, h0}, eout(0));
    endtask

    task automatic do_reset(input logic [3:0] op, input logic en);
        step(1'b0, op, en, 1'b0);
        step(1'b0, op, en, 1'b0);
        step(1'b1, op, en, 1'b0);
        chk("boot_zero", {c1, t1s, d1, h1}, 20'h0);
    endtask

    typedef struct {
        logic        r;
        logic [3:0]  op;
        logic [11:0] c;
        logic [5:0]  t;
        logic        d;
    } vec_t;

    vec_t tbl[10];
    int   cnt;
    bit   found;
    logic [3:0] rop;
    logic ren, rgo, rr;

    initial begin
        #1 reset = 1'b0;

        tbl[0] = '{1'b0, 4'h1, 12'h000, 6'b000000, 1'b0};
        tbl[1] = '{1'b0, 4'h1, 12'h000, 6'b000000, 1'b0};
        tbl[2] = '{1'b0, 4'h1, 12'h000, 6'b000000, 1'b0};
        tbl[3] = '{1'b1, 4'h1, 12'h000, 6'b000000, 1'b0};
        tbl[4] = '{1'b1, 4'h1, EP | LM, 6'b000001, 1'b0};
        tbl[5] = '{1'b1, 4'h1, CP,      6'b000010, 1'b0};
        tbl[6] = '{1'b1, 4'h1, CE | LI, 6'b000100, 1'b0};
        tbl[7] = '{1'b1, 4'h1, EI | LM, 6'b001000, 1'b0};
        tbl[8] = '{1'b1, 4'h1, CE | LA, 6'b010000, 1'b1};
        tbl[9] = '{1'b1, 4'h1, EP | LM, 6'b000001, 1'b0};

        // reset then one LDA, EARLY_END=1
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].r, tbl[i].op, 1'b0, 1'b0);
            chk($sformatf("tbl%0d", i), {c1, t1s, d1, h1},
                {tbl[i].c, tbl[i].t, tbl[i].d, 1'b0});
        end

        // ADD then SUB, six cycles each
        do_reset(4'h2, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, (i <= 6) ? 4'h2 : 4'h3, 1'b0, 1'b0);
            if (i == 6) chk("add_t6", {8'h0, c1}, {8'h0, LA | EU});
            if (i == 7) chk("add_len", {14'h0, t1s}, 20'h1);
            if (i == 12) chk("sub_t6", {8'h0, c1}, {8'h0, LA | SU | EU});
        end
        step(1'b1, 4'h3, 1'b0, 1'b0);
        chk("sub_len", {14'h0, t1s}, 20'h1);

        // opcode changed after T4 entry; then OUT
        do_reset(4'h1, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, (i <= 3) ? 4'h1 : 4'hE, 1'b0, 1'b0);
            if (i == 5) chk("lda_late_op", {c1, t1s, d1, h1},
                            {CE | LA, 6'b010000, 1'b1, 1'b0});
            if (i == 9) chk("out_t4", {c1, t1s, d1, h1},
                            {EA | LO, 6'b001000, 1'b1, 1'b0});
            if (i == 10) chk("out_len", {14'h0, t1s}, 20'h1);
        end

        // HLT, ignore everything but reset
        do_reset(4'hF, 1'b0);
        for (int i = 1; i <= 4; i++) step(1'b1, 4'hF, 1'b0, 1'b0);
        chk("hlt_t4", {c1, t1s, d1, h1}, {12'h0, 6'b001000, 2'b00});
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
            chk("halt_hold", {c1, t1s, d1, h1}, 20'h1);
        end
        step(1'b0, 4'h0, 1'b0, 1'b0);
        chk("halt_reset", {19'h0, h1}, 20'h0);
        step(1'b1, 4'h0, 1'b0, 1'b0);
        chk("halt_boot", {c1, t1s, d1, h1}, 20'h0);

        // EARLY_END=0 with NOP: done only in T6, nothing in T4..T6
        for (int i = 0; i < 13; i++) begin
            step(1'b1, 4'h0, 1'b0, 1'b0);
            chk("ee0_done", {19'h0, d0}, {19'h0, t0s == 6'b100000});
            if (t0s[5:3] != 3'b000) chk("ee0_nop_ctl", {8'h0, c0}, 20'h0);
        end

        // single step
        do_reset(4'h1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 4'h1, 1'b1, 1'b0);
            chk("wait_idle", {c1, t1s, d1, h1}, 20'h0);
        end
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 4'h1, 1'b1, 1'b1);
            if (t1s != 6'b0) cnt++;
        end
        chk("step_one", 20'(cnt), 20'd5);
        for (int i = 0; i < 3; i++) step(1'b1, 4'h1, 1'b1, 1'b0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 4'h1, 1'b1, 1'b1);
            if (t1s != 6'b0) cnt++;
        end
        chk("step_two", 20'(cnt), 20'd5);
        step(1'b1, 4'h1, 1'b0, 1'b1);
        step(1'b1, 4'h1, 1'b0, 1'b1);
        chk("wait_exit", {14'h0, t1s}, 20'h1);

        // reset during ADD T5
        do_reset(4'h2, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 4'h2, 1'b0, 1'b0);
            if (t1s == 6'b010000) found = 1'b1;
        end
        chk("find_t5", {19'h0, found}, 20'h1);
        step(1'b0, 4'h2, 1'b0, 1'b0);
        chk("mid_reset", {c1, t1s, d1, h1}, 20'h0);
        chk("mid_reset_op", {16'h0, u_ee1.op_q}, 20'h0);
        step(1'b1, 4'h2, 1'b0, 1'b0);
        chk("post_boot", {c1, t1s, d1, h1}, 20'h0);
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 4'h2, 1'b0, 1'b0);
            chk($sformatf("post_op_t%0d", i), {16'h0, u_ee1.op_q},
                (i < 4) ? 20'h0 : 20'h2);
        end

        // random traffic against the model
        ren = 1'b0;
        rgo = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rr  = ($urandom_range(0, 199) != 0);
            rop = 4'($urandom_range(0, 15));
            if (rop == 4'hF && $urandom_range(0, 7) != 0) rop = 4'h1;
            if ($urandom_range(0, 29) == 0) ren = ~ren;
            if ($urandom_range(0, 3) == 0) rgo = ~rgo;
            step(rr, rop, ren, rgo);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sap_control_unit.md
Name: sap_control_unit

Overview:
Full instruction controller for the 8-bit SAP-style datapath (PC, MAR, RAM, IR, A/B accumulators, ALU, output register). Runs a six-phase ring counter (T1..T6), decodes the IR opcode and drives the 12 bus/load control lines for every instruction. Adds HLT handling, early instruction termination and a single-step handshake for bench and demo use. Replaces the fetch-only sequencer.

Parameters:
EARLY_END, 1, 1 = jump to T1 after the last useful T-state of each opcode; 0 = always run T1..T6
OPW, 4, opcode width (fixed at 4; parameterised only for package consistency)

Ports:
- clk  in  1  system clock; all state updates on falling edge
- reset  in  1  asynchronous, active-low
- opcode  in  OPW  IR upper nibble
- step_en  in  1  1 = single-step mode
- step_go  in  1  step request; rising edge detected internally
- Cp Ep Lm Ce Li Ei La Ea Su Eu Lb Lo  out  1 each  datapath control lines
- t_state  out  6  one-hot current T-state; 0 in BOOT/WAIT/HALT
- instr_done  out  1  high during the final T-state of each instruction
- halted  out  1  high in HALT

Behaviour:
- States: BOOT, WAIT, T1..T6, HALT. The state register and op_q update on negedge clk. All outputs are a combinational Moore decode of (state, op_q), so they change only after a falling edge or on reset; the datapath samples them on the next rising edge.
- Reset (async, low): state=BOOT, op_q=0000, step edge detector cleared.
  - Every output is 0 while reset is low and throughout BOOT.
  - BOOT lasts one cycle, then goes to T1 if step_en=0, otherwise WAIT.
- Opcodes: 0000 NOP, 0001 LDA, 0010 ADD, 0011 SUB, 0100 LDB, 1110 OUT, 1111 HLT. Any other value decodes as NOP.
- op_q captures opcode on the falling edge entering T4. opcode changes after that point have no effect on the current instruction.
- Fetch, common to all opcodes:
  - T1: Ep, Lm
  - T2: Cp
  - T3: Ce, Li
- Execute (signals not listed are 0):
  - LDA: T4 Ei Lm; T5 Ce La
  - LDB: T4 Ei Lm; T5 Ce Lb
  - ADD: T4 Ei Lm; T5 Ce Lb; T6 La Eu
  - SUB: T4 Ei Lm; T5 Ce Lb; T6 La Su Eu
  - OUT: T4 Ea Lo
  - NOP: no signals
  - HLT: T4 asserts nothing; next state is HALT.
- Last T-state with EARLY_END=1: NOP T4, OUT T4, LDA T5, LDB T5, ADD T6, SUB T6.
- Last T-state with EARLY_END=0: T6 for every opcode except HLT.
- instr_done=1 in the last T-state. It is not asserted for HLT.
- Instruction boundary: after the last T-state the next state is T1 if step_en=0, otherwise WAIT.
- WAIT: all outputs 0. Leaves to T1 on the falling edge where a step_go rising edge is detected (step_go sampled on negedge, previous sample compared). A step_go held high yields exactly one instruction.
  - step_en dropping to 0 while in WAIT → T1 on the next falling edge.
- HALT: all control lines 0, halted=1. Stays there regardless of opcode, step_en and step_go; only reset exits.
- step_en changes mid-instruction take effect at the next boundary only.
- Reset mid-instruction: immediate BOOT, outputs 0, op_q cleared.
- In any state and opcode, at most one bus driver (Ep, Ce, Ei, Ea, Eu) is high. The bench checks this as an assertion.

Decomposition:
- Package sap_pkg:
  - opcode localparams (OP_NOP, OP_LDA, OP_ADD, OP_SUB, OP_LDB, OP_OUT, OP_HLT)
  - state enum
  - packed 12-bit control-word typedef, with field order Cp..Lo
  - fetch control-word constants
- One sub-module, sap_step_sync: step_go negedge sampler and rising-edge detector with async reset.
- Decode stays a function inside sap_control_unit.

Test Plan:
1. Reset low 3 cycles, release, opcode=0001, step_en=0, EARLY_END=1 → 1 cycle all-zero (BOOT); T1 Ep=Lm=1; T2 Cp=1; T3 Ce=Li=1; T4 Ei=Lm=1; T5 Ce=La=1, instr_done=1; next cycle T1 (t_state=000001).
2. opcode=0010, then a second instruction with opcode=0011 → ADD T6: La=Eu=1, Su=0; SUB T6: La=Su=Eu=1. Each instruction takes 6 cycles.
3. Drive 0001 for T1–T3, switch to 1110 only after the falling edge entering T4 → LDA sequence completes with La in T5. Separately, OUT instruction → T4 Ea=Lo=1, 4-cycle instruction.
4. opcode=1111 → T4 all zero, then halted=1 and all outputs 0 for 20 cycles while opcode, step_go and step_en toggle. Reset pulse → BOOT, halted=0.
5. EARLY_END=0, opcode=0000 → 6 cycles per instruction, instr_done only in T6, control lines 0 in T4–T6.
6. step_en=1: held in WAIT for 10 cycles with step_go=0. Raise step_go and hold 15 cycles → exactly one LDA (5 T-states) then WAIT. Second rising edge → one more instruction.
7. Assert reset in the middle of T5 of ADD → all outputs 0 before the next clock edge. After release: BOOT then T1, and op_q=0000 until the falling edge entering the next T4.
